// File: rtl/fml_ddr3_app_model.sv
// fml_ddr3_app_model: BRAM-backed responder for the MIG 7-series app_* interface.
// It stands in for the DDR3 controller. It emulates the calibration delay, periodic
// refresh back-pressure and a fixed read latency, so initiator handshakes are exercised.
module fml_ddr3_app_model #(
    parameter int ADDR_WIDTH     = 27,
    parameter int PAYLOAD_WIDTH  = 64,
    parameter int MEM_AW         = 10,
    parameter int WDF_DEPTH      = 4,
    parameter int INIT_CYCLES    = 64,
    parameter int RD_LATENCY     = 4,
    parameter int REFRESH_PERIOD = 256,
    parameter int REFRESH_STALL  = 8
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [ADDR_WIDTH-1:0]        app_addr,
    input  logic [2:0]                   app_cmd,
    input  logic                         app_en,
    output logic                         app_rdy,
    input  logic [4*PAYLOAD_WIDTH-1:0]   app_wdf_data,
    input  logic [4*PAYLOAD_WIDTH/8-1:0] app_wdf_mask,
    input  logic                         app_wdf_wren,
    input  logic                         app_wdf_end,
    output logic                         app_wdf_rdy,
    output logic [4*PAYLOAD_WIDTH-1:0]   app_rd_data,
    output logic                         app_rd_data_valid,
    output logic                         app_rd_data_end,
    output logic                         phy_init_done,
    output logic                         err_wdf_end
);
    localparam int DW  = 4 * PAYLOAD_WIDTH;
    localparam int MW  = DW / 8;
    localparam int FAW = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
    localparam int IW  = $clog2(INIT_CYCLES + 1);
    localparam int RW  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int SW  = (REFRESH_STALL > 1) ? $clog2(REFRESH_STALL) : 1;

    localparam logic [IW-1:0]  INIT_LAST  = IW'(INIT_CYCLES - 1);
    localparam logic [RW-1:0]  REF_LAST   = RW'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
    localparam logic [SW-1:0]  STALL_LAST = SW'((REFRESH_STALL > 0) ? REFRESH_STALL - 1 : 0);
    localparam logic [FAW:0]   FIFO_FULL  = (FAW + 1)'(WDF_DEPTH);
    localparam logic [2:0]     CMD_WRITE  = 3'b000;
    localparam logic [2:0]     CMD_READ   = 3'b001;

    typedef enum logic [1:0] {S_INIT, S_READY, S_WAIT_WDATA, S_REFRESH} state_t;

    state_t              state, state_next;
    logic [IW-1:0]       init_cnt;
    logic [RW-1:0]       ref_cnt;
    logic [SW-1:0]       stall_cnt;
    logic                ref_pend, ref_take, ref_expire;
    logic [MEM_AW-1:0]   cmd_idx, wait_idx, commit_idx;
    logic                rd_acc, wr_acc, wdf_push, wdf_pop;

    logic [DW-1:0]       mem [2**MEM_AW];
    logic [DW-1:0]       fifo_data [WDF_DEPTH];
    logic [MW-1:0]       fifo_mask [WDF_DEPTH];
    logic [FAW-1:0]      wr_ptr, rd_ptr;
    logic [FAW:0]        fifo_cnt;
    logic                fifo_empty;

    logic [DW-1:0]       rd_data_pipe [RD_LATENCY];
    logic [RD_LATENCY-1:0] rd_valid_pipe;

    // Column bits below a line and bits above the BRAM depth are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{app_addr[2:0], app_addr[ADDR_WIDTH-1:MEM_AW+3]};

    assign cmd_idx    = app_addr[MEM_AW+2:3];
    assign rd_acc     = app_en & app_rdy & (app_cmd == CMD_READ);
    assign wr_acc     = app_en & app_rdy & (app_cmd == CMD_WRITE);
    assign fifo_empty = (fifo_cnt == '0);
    assign app_wdf_rdy = phy_init_done & (fifo_cnt != FIFO_FULL);
    assign wdf_push   = app_wdf_wren & app_wdf_rdy;
    assign ref_expire = (REFRESH_PERIOD != 0) && phy_init_done && (ref_cnt == REF_LAST);

    assign app_rd_data       = rd_data_pipe[RD_LATENCY-1];
    assign app_rd_data_valid = rd_valid_pipe[RD_LATENCY-1];
    assign app_rd_data_end   = rd_valid_pipe[RD_LATENCY-1];

    // Next-state logic. The command offered in a READY cycle is always honoured
    // because app_rdy was already high; a due refresh takes the following cycles instead.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_next = state;
        wdf_pop    = 1'b0;
        ref_take   = 1'b0;
        commit_idx = cmd_idx;
        case (state)
            S_INIT: begin
                if (init_cnt == INIT_LAST) state_next = S_READY;
            end
            S_READY: begin
                if (wr_acc && fifo_empty) begin
                    state_next = S_WAIT_WDATA;
                end else begin
                    wdf_pop = wr_acc;
                    if (ref_expire || ref_pend) begin
                        state_next = S_REFRESH;
                        ref_take   = 1'b1;
                    end
                end
            end
            S_WAIT_WDATA: begin
                if (!fifo_empty) begin
                    wdf_pop    = 1'b1;
                    commit_idx = wait_idx;
                    if (ref_expire || ref_pend) begin
                        state_next = S_REFRESH;
                        ref_take   = 1'b1;
                    end else begin
                        state_next = S_READY;
                    end
                end
            end
            S_REFRESH: begin
                if (stall_cnt == STALL_LAST) state_next = S_READY;
            end
            default: state_next = S_INIT;
        endcase
    end

    // Control state: FSM, calibration/refresh counters, FIFO pointers, sticky error.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!sys_rst) begin
            state         <= S_INIT;
            app_rdy       <= 1'b0;
            phy_init_done <= 1'b0;
            init_cnt      <= '0;
            ref_cnt       <= '0;
            ref_pend      <= 1'b0;
            stall_cnt     <= '0;
            wait_idx      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            err_wdf_end   <= 1'b0;
        end else begin
            state   <= state_next;
            app_rdy <= (state_next == S_READY);
            if (state == S_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (state_next == S_READY) phy_init_done <= 1'b1;
            end
            if (phy_init_done) ref_cnt <= ref_expire ? '0 : ref_cnt + 1'b1;
            ref_pend  <= (ref_pend | ref_expire) & ~ref_take;
            stall_cnt <= (state == S_REFRESH) ? stall_cnt + 1'b1 : '0;
            if (state == S_READY && wr_acc && fifo_empty) wait_idx <= cmd_idx;
            if (wdf_push) wr_ptr <= wr_ptr + 1'b1;
            if (wdf_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({wdf_push, wdf_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (wdf_push && !app_wdf_end) err_wdf_end <= 1'b1;
        end
    end

    // Storage: FIFO entry capture and byte-masked commit of the FIFO head into BRAM.
    always_ff @(posedge sys_clk) begin
        // NOTE: storage arrays have no reset; they map onto RAM that cannot be cleared.
        if (wdf_push) begin
            fifo_data[wr_ptr] <= app_wdf_data;
            fifo_mask[wr_ptr] <= app_wdf_mask;
        end
        if (wdf_pop) begin
            for (int b = 0; b < MW; b++) begin
                if (!fifo_mask[rd_ptr][b]) mem[commit_idx][b*8 +: 8] <= fifo_data[rd_ptr][b*8 +: 8];
            end
        end
    end

    // Read path: BRAM output register followed by a fixed-length valid/data pipe.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            rd_valid_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) rd_data_pipe[i] <= '0;
        end else begin
            rd_valid_pipe <= {rd_valid_pipe[RD_LATENCY-2:0], rd_acc};
            if (rd_acc) rd_data_pipe[0] <= mem[cmd_idx];
            for (int i = 1; i < RD_LATENCY; i++) rd_data_pipe[i] <= rd_data_pipe[i-1];
        end
    end
endmodule

// File: tb/tb_fml_ddr3_app_model.sv
// Directed bench for fml_ddr3_app_model: one instance with refresh disabled for the
// data-path checks, one with a short refresh period for stall and reset behaviour.
module tb_fml_ddr3_app_model;
    localparam int DW = 256;
    localparam int MW = 32;
    localparam int AW = 27;
    localparam logic [2:0] WR = 3'b000;
    localparam logic [2:0] RD = 3'b001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (refresh disabled)
    logic          rst, en, rdy, wren, wend, wdf_rdy, rvalid, rend, init_done, err_end;
    logic [AW-1:0] addr;
    logic [2:0]    cmd;
    logic [DW-1:0] wdata, rdata;
    logic [MW-1:0] wmask;
    // refresh instance
    logic          rst_r, en_r, rdy_r, wdf_rdy_r, rvalid_r, rend_r, init_done_r, err_end_r;
    logic [AW-1:0] addr_r;
    logic [2:0]    cmd_r;
    logic [DW-1:0] rdata_r;

    int checks = 0;
    int errors = 0;

    fml_ddr3_app_model #(.REFRESH_PERIOD(0)) dut (
        .sys_clk(clk), .sys_rst(rst), .app_addr(addr), .app_cmd(cmd), .app_en(en),
        .app_rdy(rdy), .app_wdf_data(wdata), .app_wdf_mask(wmask), .app_wdf_wren(wren),
        .app_wdf_end(wend), .app_wdf_rdy(wdf_rdy), .app_rd_data(rdata),
        .app_rd_data_valid(rvalid), .app_rd_data_end(rend), .phy_init_done(init_done),
        .err_wdf_end(err_end));

    fml_ddr3_app_model #(.REFRESH_PERIOD(16), .REFRESH_STALL(3)) dut_r (
        .sys_clk(clk), .sys_rst(rst_r), .app_addr(addr_r), .app_cmd(cmd_r), .app_en(en_r),
        .app_rdy(rdy_r), .app_wdf_data('0), .app_wdf_mask('0), .app_wdf_wren(1'b0),
        .app_wdf_end(1'b0), .app_wdf_rdy(wdf_rdy_r), .app_rd_data(rdata_r),
        .app_rd_data_valid(rvalid_r), .app_rd_data_end(rend_r), .phy_init_done(init_done_r),
        .err_wdf_end(err_end_r));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic init_main(input string tag);
        int  n = 0;
        bit  early = 1'b0;
        while (!init_done && n < 200) begin
            if (rdy || wdf_rdy) early = 1'b1;
            tick();
            n++;
        end
        check({tag, "_cycles"}, n, 64);
        check({tag, "_early_rdy"}, early, 0);
        check({tag, "_rdy"}, rdy, 1);
        check({tag, "_wdf_rdy"}, wdf_rdy, 1);
    endtask

    task automatic init_ref(input string tag);
        int  n = 0;
        bit  early = 1'b0;
        while (!init_done_r && n < 200) begin
            if (rdy_r || wdf_rdy_r) early = 1'b1;
            tick();
            n++;
        end
        check({tag, "_cycles"}, n, 64);
        check({tag, "_early_rdy"}, early, 0);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic e);
        int n = 0;
        while (!wdf_rdy && n < 50) begin tick(); n++; end
        check("push_wdf_rdy", wdf_rdy, 1);
        wdata = d; wmask = m; wren = 1'b1; wend = e;
        tick();
        wren = 1'b0; wend = 1'b0;
    endtask

    task automatic issue(input logic [2:0] c, input logic [AW-1:0] a);
        int n = 0;
        while (!rdy && n < 50) begin tick(); n++; end
        check("cmd_rdy", rdy, 1);
        cmd = c; addr = a; en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int lat;
        issue(RD, a);
        lat = 1;
        while (!rvalid && lat < 20) begin tick(); lat++; end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_data"}, rdata, exp);
        check({tag, "_end"}, rend, 1);
        tick();
        check({tag, "_one_cycle"}, rvalid, 0);
    endtask

    initial begin
        logic [DW-1:0] d1, d2, d2m, e1, f1;
        logic [DW-1:0] b [4];
        logic [DW-1:0] cap [4];
        logic [11:0]   vmask;
        int got, lows, n, lowlen, vcount;

        rst = 1'b0; en = 1'b0; cmd = '0; addr = '0; wdata = '0; wmask = '0; wren = 1'b0; wend = 1'b0;
        rst_r = 1'b0; en_r = 1'b0; cmd_r = '0; addr_r = '0;
        tick(); tick();

        // reset state
        check("rst_app_rdy", rdy, 0);
        check("rst_wdf_rdy", wdf_rdy, 0);
        check("rst_init_done", init_done, 0);
        check("rst_rd_valid", rvalid, 0);
        check("rst_err_end", err_end, 0);

        // calibration delay
        rst = 1'b1;
        init_main("init");

        // data pushed before command, then read back
        d1 = {32{8'hA5}};
        push(d1, '0, 1'b1);
        issue(WR, 27'h40);
        read_check("raw_40", 27'h40, d1);

        // full write of a known pattern, then masked write with empty FIFO
        for (int i = 0; i < MW; i++) d2[i*8 +: 8] = 8'(8'h10 + i);
        push(d2, '0, 1'b1);
        issue(WR, 27'h08);
        issue(WR, 27'h08);
        check("wait_wdata_rdy_low", rdy, 0);
        tick(); tick();
        check("wait_wdata_rdy_hold", rdy, 0);
        push({32{8'h5A}}, 32'hFFFF_FFFE, 1'b1);
        check("wait_commit_rdy_low", rdy, 0);
        tick();
        check("wait_commit_rdy_back", rdy, 1);
        d2m = d2;
        d2m[7:0] = 8'h5A;
        read_check("mask_08", 27'h08, d2m);

        // fill FIFO with no commands, then drain in order
        for (int k = 0; k < 4; k++) begin
            b[k] = {32{8'(8'h30 + k)}};
            push(b[k], '0, 1'b1);
        end
        check("fifo_full_wdf_rdy", wdf_rdy, 0);
        for (int k = 0; k < 4; k++) begin
            issue(WR, AW'(k * 8));
            if (k == 0) check("fifo_pop_wdf_rdy", wdf_rdy, 1);
        end

        // back-to-back reads: valids on four consecutive cycles, in order
        vmask = '0;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin en = 1'b1; cmd = RD; addr = AW'(i * 8); end
            else en = 1'b0;
            tick();
            vmask[i] = rvalid;
            if (rvalid && got < 4) begin cap[got] = rdata; got++; end
        end
        check("b2b_valid_pattern", vmask, 12'h078);
        for (int k = 0; k < 4; k++) check("b2b_data", cap[k], b[k]);

        // address aliasing modulo BRAM depth
        read_check("alias_2000", 27'h2000, b[0]);

        // non read/write command has no effect
        issue(3'b010, 27'h18);
        read_check("nop_18", 27'h18, b[3]);

        // beat pushed with wdf_end low: stored, flags sticky error
        check("err_clear", err_end, 0);
        e1 = {16{16'hBEEF}};
        push(e1, '0, 1'b0);
        check("err_set", err_end, 1);
        issue(WR, 27'h30);
        read_check("noend_30", 27'h30, e1);
        check("err_sticky", err_end, 1);

        // data pushed on the same edge as a write command to an empty FIFO
        f1 = {8{32'hC0DE_0001}};
        wdata = f1; wmask = '0; wren = 1'b1; wend = 1'b1;
        cmd = WR; addr = 27'h38; en = 1'b1;
        tick();
        wren = 1'b0; wend = 1'b0; en = 1'b0;
        check("same_edge_rdy_low", rdy, 0);
        tick();
        check("same_edge_rdy_back", rdy, 1);
        read_check("same_edge_38", 27'h38, f1);

        // refresh disabled: app_rdy never drops while idle
        lows = 0;
        repeat (40) begin tick(); if (!rdy) lows++; end
        check("no_refresh_lows", lows, 0);

        // refresh instance: stall timing
        rst_r = 1'b1;
        init_ref("r_init");
        n = 0;
        while (rdy_r && n < 40) begin tick(); n++; end
        check("ref_first_fall", n, 16);
        lowlen = 0;
        while (!rdy_r && lowlen < 20) begin tick(); lowlen++; end
        check("ref_stall_len", lowlen, 3);
        n = 0;
        while (rdy_r && n < 40) begin tick(); n++; end
        check("ref_period", lowlen + n, 16);

        // reset in the middle of a stall restarts calibration
        tick();
        rst_r = 1'b0;
        tick(); tick();
        check("stall_rst_rdy", rdy_r, 0);
        check("stall_rst_init_done", init_done_r, 0);
        rst_r = 1'b1;
        init_ref("r_reinit");

        // reset with a read in flight: no valid ever emitted
        check("r_read_rdy", rdy_r, 1);
        vcount = 0;
        en_r = 1'b1; cmd_r = RD; addr_r = '0;
        tick();
        en_r = 1'b0;
        tick();
        if (rvalid_r) vcount++;
        rst_r = 1'b0;
        tick();
        if (rvalid_r) vcount++;
        check("read_rst_init_done", init_done_r, 0);
        check("read_rst_rdy", rdy_r, 0);
        rst_r = 1'b1;
        repeat (10) begin tick(); if (rvalid_r) vcount++; end
        check("read_rst_no_valid", vcount, 0);
        check("read_rst_still_init", init_done_r, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end
endmodule
